id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Pipeline register between instruction decode and execute in the RISC-V core.
- Captures the control word produced by the decoder (jal, auipc, branch, mem-read, mem-to-reg, mem-write, ALU-src, reg-write, ALU-op) together with decoded operands. Presents them to EX one cycle later.
- Contains load-use hazard detection: drives a stall to PC/IF-ID and inserts bubbles.
- Supports flush on taken branch/jump, and keeps saturating stall/flush event counters.

Parameters:
DATA_WIDTH, 32, width of PC, register data and immediate
CNT_WIDTH, 16, width of each saturating event counter

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
Valid_i  input  1  ID slot holds a real instruction (0 = upstream bubble)
Flush_i  input  1  EX resolved taken branch/jump; kill the instruction now in ID
Jal_i / Jal_o  in/out  2  jump type (00 none, 10 jal, 11 jalr)
Auipc_i / Auipc_o  in/out  1  U-type (auipc or lui)
Branch_i / Branch_o  in/out  1  conditional branch
Mem_Read_i / Mem_Read_o  in/out  1  load
Mem_to_Reg_i / Mem_to_Reg_o  in/out  2  writeback source select
Mem_Write_i / Mem_Write_o  in/out  1  store
ALU_Src_i / ALU_Src_o  in/out  1  ALU operand B = immediate
Reg_Write_i / Reg_Write_o  in/out  1  writes rd
ALU_Op_i / ALU_Op_o  in/out  3  ALU operation class
PC_i / PC_o  in/out  DATA_WIDTH  instruction PC
Rs1_Data_i / Rs1_Data_o, Rs2_Data_i / Rs2_Data_o  in/out  DATA_WIDTH  register file read data
Imm_i / Imm_o  in/out  DATA_WIDTH  sign-extended immediate
Rs1_Addr_i / Rs1_Addr_o, Rs2_Addr_i / Rs2_Addr_o, Rd_Addr_i / Rd_Addr_o  in/out  5  register indices
Funct3_i / Funct3_o  in/out  3  funct3
Funct7_b5_i / Funct7_b5_o  in/out  1  instruction bit 30
Valid_o  output  1  EX slot holds a real instruction
Stall_o  output  1  hold PC and IF/ID this cycle (combinational)
Stall_Count_o  output  CNT_WIDTH  cycles with Stall_o=1
Flush_Count_o  output  CNT_WIDTH  cycles with Flush_i=1

Behaviour:
- Reset (synchronous, highest priority):
  - All registered outputs go to 0, including Valid_o and both counters.
  - Stall_o is 0 while Valid_o=0.
- Source-use decode, on ID inputs:
  - rs1_used = !(Jal_i==2'b10) && !Auipc_i
  - rs2_used = Mem_Write_i || (Jal_i==2'b00 && !ALU_Src_i && (Reg_Write_i || Branch_i))
- Hazard (combinational from registered EX state):
  - hazard = Valid_i && Valid_o && Mem_Read_o && Rd_Addr_o!=0 && ((rs1_used && Rs1_Addr_i==Rd_Addr_o) || (rs2_used && Rs2_Addr_i==Rd_Addr_o))
  - Stall_o = hazard && !Flush_i
- Per rising edge, priority order:
  1. reset
  2. Flush_i=1: bubble
  3. hazard=1: bubble
  4. otherwise capture
- Capture:
  - All _o fields take their _i values one cycle later (latency 1).
  - Valid_o <= Valid_i.
- Bubble:
  - Valid_o <= 0.
  - Jal, Auipc, Branch, Mem_Read, Mem_to_Reg, Mem_Write, ALU_Src, Reg_Write, ALU_Op all <= 0.
  - Data/address fields still capture their inputs; EX must not use them when Valid_o=0.
- Upstream bubble (Valid_i=0, no flush/hazard):
  - Captured as-is, but control fields are forced to 0.
  - Control outputs are therefore always 0 whenever Valid_o=0.
- Stall and flush in the same cycle: flush wins, Stall_o=0, bubble inserted.
- A stall lasts exactly one cycle per load-use pair:
  - Next cycle EX holds the bubble, so Mem_Read_o=0 and hazard clears.
  - Consecutive loads feeding each other stall once per pair.
- Counters:
  - Stall_Count_o increments on each cycle with Stall_o=1.
  - Flush_Count_o increments on each cycle with Flush_i=1.
  - Both saturate at all-ones and never wrap.
  - Cleared only by reset; no increment during the reset cycle.
- Reset mid-operation overrides any pending stall or flush; first post-reset edge is a normal capture.

Test Plan:
- Reset → Valid_o=0, all control outputs 0, Stall_o=0, counters 0. Release reset with add (Reg_Write=1, ALU_Op=000, PC=0x100) → next cycle Valid_o=1, PC_o=0x100, Reg_Write_o=1.
- lw x5,0(x1) followed by add x6,x5,x2 → Stall_o=1 for exactly one cycle, EX gets bubble (Valid_o=0, Mem_Read_o=0), Stall_Count_o=1, add reaches EX the following cycle.
- lw x5 followed by addi x6,x7,4 with Rs2_Addr_i=5 (rs2 unused since ALU_Src=1) → no stall. lw x0 followed by add x6,x0,x0 → no stall.
- Load-use hazard present and Flush_i=1 same cycle → Stall_o=0, bubble inserted, Flush_Count_o increments by 1, Stall_Count_o unchanged.
- lw x5 followed by lui x5 (Auipc=1) and by jal (Jal=10) with Rs1_Addr_i=5 → no stall. jalr using x5 → one-cycle stall.
- CNT_WIDTH=2 with 5 consecutive flush cycles → Flush_Count_o reads 1,2,3,3,3. Assert reset during a stall cycle → next cycle all outputs 0.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decoder-side inputs (_i), EX-side registered outputs (_o),
// hazard stall and event counters. master = decode/test side, slave = stage register.
interface id_ex_stage_reg_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  Valid_i;
  logic                  Flush_i;
  logic [1:0]            Jal_i;
  logic                  Auipc_i;
  logic                  Branch_i;
  logic                  Mem_Read_i;
  logic [1:0]            Mem_to_Reg_i;
  logic                  Mem_Write_i;
  logic                  ALU_Src_i;
  logic                  Reg_Write_i;
  logic [2:0]            ALU_Op_i;
  logic [DATA_WIDTH-1:0] PC_i;
  logic [DATA_WIDTH-1:0] Rs1_Data_i;
  logic [DATA_WIDTH-1:0] Rs2_Data_i;
  logic [DATA_WIDTH-1:0] Imm_i;
  logic [4:0]            Rs1_Addr_i;
  logic [4:0]            Rs2_Addr_i;
  logic [4:0]            Rd_Addr_i;
  logic [2:0]            Funct3_i;
  logic                  Funct7_b5_i;

  logic                  Valid_o;
  logic [1:0]            Jal_o;
  logic                  Auipc_o;
  logic                  Branch_o;
  logic                  Mem_Read_o;
  logic [1:0]            Mem_to_Reg_o;
  logic                  Mem_Write_o;
  logic                  ALU_Src_o;
  logic                  Reg_Write_o;
  logic [2:0]            ALU_Op_o;
  logic [DATA_WIDTH-1:0] PC_o;
  logic [DATA_WIDTH-1:0] Rs1_Data_o;
  logic [DATA_WIDTH-1:0] Rs2_Data_o;
  logic [DATA_WIDTH-1:0] Imm_o;
  logic [4:0]            Rs1_Addr_o;
  logic [4:0]            Rs2_Addr_o;
  logic [4:0]            Rd_Addr_o;
  logic [2:0]            Funct3_o;
  logic                  Funct7_b5_o;
  logic                  Stall_o;
  logic [CNT_WIDTH-1:0]  Stall_Count_o;
  logic [CNT_WIDTH-1:0]  Flush_Count_o;

  modport master (
    output Valid_i, Flush_i, Jal_i, Auipc_i, Branch_i, Mem_Read_i, Mem_to_Reg_i,
           Mem_Write_i, ALU_Src_i, Reg_Write_i, ALU_Op_i, PC_i, Rs1_Data_i,
           Rs2_Data_i, Imm_i, Rs1_Addr_i, Rs2_Addr_i, Rd_Addr_i, Funct3_i, Funct7_b5_i,
    input  Valid_o, Jal_o, Auipc_o, Branch_o, Mem_Read_o, Mem_to_Reg_o,
           Mem_Write_o, ALU_Src_o, Reg_Write_o, ALU_Op_o, PC_o, Rs1_Data_o,
           Rs2_Data_o, Imm_o, Rs1_Addr_o, Rs2_Addr_o, Rd_Addr_o, Funct3_o, Funct7_b5_o,
           Stall_o, Stall_Count_o, Flush_Count_o
  );

  modport slave (
    input  Valid_i, Flush_i, Jal_i, Auipc_i, Branch_i, Mem_Read_i, Mem_to_Reg_i,
           Mem_Write_i, ALU_Src_i, Reg_Write_i, ALU_Op_i, PC_i, Rs1_Data_i,
           Rs2_Data_i, Imm_i, Rs1_Addr_i, Rs2_Addr_i, Rd_Addr_i, Funct3_i, Funct7_b5_i,
    output Valid_o, Jal_o, Auipc_o, Branch_o, Mem_Read_o, Mem_to_Reg_o,
           Mem_Write_o, ALU_Src_o, Reg_Write_o, ALU_Op_o, PC_o, Rs1_Data_o,
           Rs2_Data_o, Imm_o, Rs1_Addr_o, Rs2_Addr_o, Rd_Addr_o, Funct3_o, Funct7_b5_o,
           Stall_o, Stall_Count_o, Flush_Count_o
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// flush/stall, and saturating stall/flush event counters.
module id_ex_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic             clk,
  input logic             reset,
  id_ex_stage_reg_if.slave ifc
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic                  valid_p0;
  logic [1:0]            jal_p0;
  logic                  auipc_p0, branch_p0, mem_read_p0;
  logic [1:0]            mem_to_reg_p0;
  logic                  mem_write_p0, alu_src_p0, reg_write_p0;
  logic [2:0]            alu_op_p0;
  logic [DATA_WIDTH-1:0] pc_p0, rs1_data_p0, rs2_data_p0, imm_p0;
  logic [4:0]            rs1_addr_p0, rs2_addr_p0, rd_addr_p0;
  logic [2:0]            funct3_p0;
  logic                  funct7_b5_p0;
  logic [CNT_WIDTH-1:0]  stall_cnt_p0, flush_cnt_p0;

  logic rs1_used, rs2_used, hazard, stall, take_ctrl;

  // Source-use decode: jal/lui/auipc ignore rs1; rs2 only for stores and R-type/branches.
  assign rs1_used  = !(ifc.Jal_i == 2'b10) && !ifc.Auipc_i;
  assign rs2_used  = ifc.Mem_Write_i ||
                     (ifc.Jal_i == 2'b00 && !ifc.ALU_Src_i && (ifc.Reg_Write_i || ifc.Branch_i));
  assign hazard    = ifc.Valid_i && valid_p0 && mem_read_p0 && (rd_addr_p0 != 5'd0) &&
                     ((rs1_used && ifc.Rs1_Addr_i == rd_addr_p0) ||
                      (rs2_used && ifc.Rs2_Addr_i == rd_addr_p0));
  assign stall     = hazard && !ifc.Flush_i;
  assign take_ctrl = ifc.Valid_i && !ifc.Flush_i && !hazard;

  // ---- stage p0: ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_p0      <= 1'b0;
      jal_p0        <= '0;
      auipc_p0      <= 1'b0;
      branch_p0     <= 1'b0;
      mem_read_p0   <= 1'b0;
      mem_to_reg_p0 <= '0;
      mem_write_p0  <= 1'b0;
      alu_src_p0    <= 1'b0;
      reg_write_p0  <= 1'b0;
      alu_op_p0     <= '0;
      pc_p0         <= '0;
      rs1_data_p0   <= '0;
      rs2_data_p0   <= '0;
      imm_p0        <= '0;
      rs1_addr_p0   <= '0;
      rs2_addr_p0   <= '0;
      rd_addr_p0    <= '0;
      funct3_p0     <= '0;
      funct7_b5_p0  <= 1'b0;
      stall_cnt_p0  <= '0;
      flush_cnt_p0  <= '0;
    end else begin
      valid_p0      <= take_ctrl;
      jal_p0        <= take_ctrl ? ifc.Jal_i        : 2'b00;
      auipc_p0      <= take_ctrl ? ifc.Auipc_i      : 1'b0;
      branch_p0     <= take_ctrl ? ifc.Branch_i     : 1'b0;
      mem_read_p0   <= take_ctrl ? ifc.Mem_Read_i   : 1'b0;
      mem_to_reg_p0 <= take_ctrl ? ifc.Mem_to_Reg_i : 2'b00;
      mem_write_p0  <= take_ctrl ? ifc.Mem_Write_i  : 1'b0;
      alu_src_p0    <= take_ctrl ? ifc.ALU_Src_i    : 1'b0;
      reg_write_p0  <= take_ctrl ? ifc.Reg_Write_i  : 1'b0;
      alu_op_p0     <= take_ctrl ? ifc.ALU_Op_i     : 3'b000;
      // Operand fields always capture; EX qualifies them with Valid_o.
      pc_p0         <= ifc.PC_i;
      rs1_data_p0   <= ifc.Rs1_Data_i;
      rs2_data_p0   <= ifc.Rs2_Data_i;
      imm_p0        <= ifc.Imm_i;
      rs1_addr_p0   <= ifc.Rs1_Addr_i;
      rs2_addr_p0   <= ifc.Rs2_Addr_i;
      rd_addr_p0    <= ifc.Rd_Addr_i;
      funct3_p0     <= ifc.Funct3_i;
      funct7_b5_p0  <= ifc.Funct7_b5_i;
      if (stall)       stall_cnt_p0 <= sat_inc(stall_cnt_p0);
      if (ifc.Flush_i) flush_cnt_p0 <= sat_inc(flush_cnt_p0);
    end
  end

  assign ifc.Valid_o       = valid_p0;
  assign ifc.Jal_o         = jal_p0;
  assign ifc.Auipc_o       = auipc_p0;
  assign ifc.Branch_o      = branch_p0;
  assign ifc.Mem_Read_o    = mem_read_p0;
  assign ifc.Mem_to_Reg_o  = mem_to_reg_p0;
  assign ifc.Mem_Write_o   = mem_write_p0;
  assign ifc.ALU_Src_o     = alu_src_p0;
  assign ifc.Reg_Write_o   = reg_write_p0;
  assign ifc.ALU_Op_o      = alu_op_p0;
  assign ifc.PC_o          = pc_p0;
  assign ifc.Rs1_Data_o    = rs1_data_p0;
  assign ifc.Rs2_Data_o    = rs2_data_p0;
  assign ifc.Imm_o         = imm_p0;
  assign ifc.Rs1_Addr_o    = rs1_addr_p0;
  assign ifc.Rs2_Addr_o    = rs2_addr_p0;
  assign ifc.Rd_Addr_o     = rd_addr_p0;
  assign ifc.Funct3_o      = funct3_p0;
  assign ifc.Funct7_b5_o   = funct7_b5_p0;
  assign ifc.Stall_o       = stall;
  assign ifc.Stall_Count_o = stall_cnt_p0;
  assign ifc.Flush_Count_o = flush_cnt_p0;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: small hazard/capture model feeds a scoreboard
// queue; a second 2-bit-counter instance exercises counter saturation.
module tb_id_ex_stage_reg;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) ifs1 ();
  id_ex_stage_reg_if #(.DATA_WIDTH(32), .CNT_WIDTH(2))  ifs2 ();

  id_ex_stage_reg #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (.clk(clk), .reset(reset), .ifc(ifs1));
  id_ex_stage_reg #(.DATA_WIDTH(32), .CNT_WIDTH(2))  dut2 (.clk(clk), .reset(reset), .ifc(ifs2));

  typedef struct packed {
    logic        vld;
    logic [1:0]  jal;
    logic        auipc, branch, mr;
    logic [1:0]  m2r;
    logic        mw, alu_src, rw;
    logic [2:0]  alu_op;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
  } instr_t;

  typedef struct packed {
    logic        valid;
    logic [12:0] ctrl;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [15:0] scnt, fcnt;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic        m_vld = 1'b0, m_mr = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [15:0] m_scnt = '0, m_fcnt = '0;

  function automatic instr_t mk(input logic vld, input logic [1:0] jal, input logic auipc,
                                input logic branch, input logic mr, input logic [1:0] m2r,
                                input logic mw, input logic alu_src, input logic rw,
                                input logic [2:0] alu_op, input logic [31:0] pc,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    instr_t t;
    t.vld = vld; t.jal = jal; t.auipc = auipc; t.branch = branch; t.mr = mr; t.m2r = m2r;
    t.mw = mw; t.alu_src = alu_src; t.rw = rw; t.alu_op = alu_op; t.pc = pc;
    t.r1d = pc ^ 32'hA5A5_5A5A; t.r2d = ~pc; t.imm = pc + 32'd4;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.f3 = pc[4:2]; t.f7 = pc[3];
    return t;
  endfunction

  function automatic logic [12:0] ctrl_of(input instr_t t);
    return {t.jal, t.auipc, t.branch, t.mr, t.m2r, t.mw, t.alu_src, t.rw, t.alu_op};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input instr_t t, input logic fl);
    ifs1.Valid_i = t.vld;        ifs1.Flush_i = fl;          ifs1.Jal_i = t.jal;
    ifs1.Auipc_i = t.auipc;      ifs1.Branch_i = t.branch;   ifs1.Mem_Read_i = t.mr;
    ifs1.Mem_to_Reg_i = t.m2r;   ifs1.Mem_Write_i = t.mw;    ifs1.ALU_Src_i = t.alu_src;
    ifs1.Reg_Write_i = t.rw;     ifs1.ALU_Op_i = t.alu_op;   ifs1.PC_i = t.pc;
    ifs1.Rs1_Data_i = t.r1d;     ifs1.Rs2_Data_i = t.r2d;    ifs1.Imm_i = t.imm;
    ifs1.Rs1_Addr_i = t.rs1;     ifs1.Rs2_Addr_i = t.rs2;    ifs1.Rd_Addr_i = t.rd;
    ifs1.Funct3_i = t.f3;        ifs1.Funct7_b5_i = t.f7;
  endtask

  // One clock: drive at negedge, check combinational stall, push expectation, compare after edge.
  task automatic step(input instr_t t, input logic fl, input logic rst, input string tag);
    exp_t e, got;
    logic u1, u2, haz, stl, cap;
    @(negedge clk);
    drive(t, fl);
    reset = rst;
    u1  = !(t.jal == 2'b10) && !t.auipc;
    u2  = t.mw || (t.jal == 2'b00 && !t.alu_src && (t.rw || t.branch));
    haz = t.vld && m_vld && m_mr && (m_rd != 5'd0) &&
          ((u1 && t.rs1 == m_rd) || (u2 && t.rs2 == m_rd));
    stl = haz && !fl;
    cap = t.vld && !fl && !haz;
    #1;
    chk({tag, ":stall"}, 128'(ifs1.Stall_o), 128'(stl));
    if (rst) begin
      e = '0;
      m_vld = 1'b0; m_mr = 1'b0; m_rd = '0; m_scnt = '0; m_fcnt = '0;
    end else begin
      if (stl && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
      if (fl && m_fcnt != 16'hFFFF)  m_fcnt = m_fcnt + 16'd1;
      e.valid = cap;
      e.ctrl  = cap ? ctrl_of(t) : 13'd0;
      e.pc = t.pc; e.r1d = t.r1d; e.r2d = t.r2d; e.imm = t.imm;
      e.rs1 = t.rs1; e.rs2 = t.rs2; e.rd = t.rd; e.f3 = t.f3; e.f7 = t.f7;
      e.scnt = m_scnt; e.fcnt = m_fcnt;
      m_vld = cap; m_mr = cap && t.mr; m_rd = t.rd;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0;
    got = sb.pop_front();
    chk({tag, ":valid"}, 128'(ifs1.Valid_o), 128'(got.valid));
    chk({tag, ":ctrl"}, 128'({ifs1.Jal_o, ifs1.Auipc_o, ifs1.Branch_o, ifs1.Mem_Read_o,
                              ifs1.Mem_to_Reg_o, ifs1.Mem_Write_o, ifs1.ALU_Src_o,
                              ifs1.Reg_Write_o, ifs1.ALU_Op_o}), 128'(got.ctrl));
    chk({tag, ":data"}, {ifs1.PC_o, ifs1.Rs1_Data_o, ifs1.Rs2_Data_o, ifs1.Imm_o},
        {got.pc, got.r1d, got.r2d, got.imm});
    chk({tag, ":addr"}, 128'({ifs1.Rs1_Addr_o, ifs1.Rs2_Addr_o, ifs1.Rd_Addr_o,
                              ifs1.Funct3_o, ifs1.Funct7_b5_o}),
        128'({got.rs1, got.rs2, got.rd, got.f3, got.f7}));
    chk({tag, ":stall_cnt"}, 128'(ifs1.Stall_Count_o), 128'(got.scnt));
    chk({tag, ":flush_cnt"}, 128'(ifs1.Flush_Count_o), 128'(got.fcnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t nop, add, lw5, use5, addi, lw0, add0, lui5, jal5, jalr5, ubub, lw6, use6, sw5;
    logic [1:0] c2;
    nop   = mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 32'h0,   5'd0, 5'd0, 5'd0);
    add   = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 3'b000, 32'h100, 5'd1, 5'd2, 5'd3);
    lw5   = mk(1, 2'b00, 0, 0, 1, 2'b01, 0, 1, 1, 3'b000, 32'h104, 5'd1, 5'd0, 5'd5);
    use5  = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 3'b000, 32'h108, 5'd5, 5'd2, 5'd6);
    addi  = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 1, 1, 3'b000, 32'h10C, 5'd7, 5'd5, 5'd6);
    lw0   = mk(1, 2'b00, 0, 0, 1, 2'b01, 0, 1, 1, 3'b000, 32'h110, 5'd1, 5'd0, 5'd0);
    add0  = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 3'b000, 32'h114, 5'd0, 5'd0, 5'd6);
    lui5  = mk(1, 2'b00, 1, 0, 0, 2'b00, 0, 1, 1, 3'b000, 32'h118, 5'd5, 5'd0, 5'd5);
    jal5  = mk(1, 2'b10, 0, 0, 0, 2'b10, 0, 1, 1, 3'b000, 32'h11C, 5'd5, 5'd5, 5'd1);
    jalr5 = mk(1, 2'b11, 0, 0, 0, 2'b10, 0, 1, 1, 3'b000, 32'h120, 5'd5, 5'd0, 5'd1);
    ubub  = mk(0, 2'b11, 1, 1, 1, 2'b11, 1, 1, 1, 3'b111, 32'h124, 5'd5, 5'd5, 5'd9);
    lw6   = mk(1, 2'b00, 0, 0, 1, 2'b01, 0, 1, 1, 3'b000, 32'h128, 5'd5, 5'd0, 5'd6);
    use6  = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 3'b010, 32'h12C, 5'd2, 5'd6, 5'd7);
    sw5   = mk(1, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 3'b000, 32'h130, 5'd1, 5'd5, 5'd0);

    ifs2.Valid_i = 0; ifs2.Flush_i = 0; ifs2.Jal_i = '0; ifs2.Auipc_i = 0; ifs2.Branch_i = 0;
    ifs2.Mem_Read_i = 0; ifs2.Mem_to_Reg_i = '0; ifs2.Mem_Write_i = 0; ifs2.ALU_Src_i = 0;
    ifs2.Reg_Write_i = 0; ifs2.ALU_Op_i = '0; ifs2.PC_i = '0; ifs2.Rs1_Data_i = '0;
    ifs2.Rs2_Data_i = '0; ifs2.Imm_i = '0; ifs2.Rs1_Addr_i = '0; ifs2.Rs2_Addr_i = '0;
    ifs2.Rd_Addr_i = '0; ifs2.Funct3_i = '0; ifs2.Funct7_b5_i = 0;
    drive(nop, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    step(nop, 0, 1, "reset");
    step(add, 0, 0, "add_first");
    step(lw5, 0, 0, "lw5");
    step(use5, 0, 0, "loaduse_stall");
    step(use5, 0, 0, "loaduse_release");
    step(lw5, 0, 0, "lw5_b");
    step(addi, 0, 0, "addi_rs2_unused");
    step(lw0, 0, 0, "lw_x0");
    step(add0, 0, 0, "add_x0_nostall");
    step(lw5, 0, 0, "lw5_c");
    step(use5, 1, 0, "stall_vs_flush");
    step(lw5, 0, 0, "lw5_d");
    step(lui5, 0, 0, "lui_nostall");
    step(lw5, 0, 0, "lw5_e");
    step(jal5, 0, 0, "jal_nostall");
    step(lw5, 0, 0, "lw5_f");
    step(jalr5, 0, 0, "jalr_stall");
    step(jalr5, 0, 0, "jalr_release");
    step(ubub, 0, 0, "upstream_bubble");
    step(lw5, 0, 0, "lw5_g");
    step(lw6, 0, 0, "lw_lw_stall");
    step(lw6, 0, 0, "lw_lw_release");
    step(use6, 0, 0, "lw6_use_stall");
    step(use6, 0, 0, "lw6_use_release");
    step(lw5, 0, 0, "lw5_h");
    step(sw5, 0, 0, "store_rs2_stall");
    step(sw5, 0, 0, "store_release");
    step(add, 1, 0, "plain_flush");
    step(lw5, 0, 0, "lw5_i");
    step(use5, 0, 1, "reset_in_stall");
    step(add, 0, 0, "post_reset_capture");

    @(negedge clk);
    drive(nop, 1'b0);
    chk("sat_start", 128'(ifs2.Flush_Count_o), 128'(2'd0));
    ifs2.Flush_i = 1'b1;
    c2 = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      c2 = (c2 == 2'd3) ? 2'd3 : c2 + 2'd1;
      chk($sformatf("flush_sat_%0d", i), 128'(ifs2.Flush_Count_o), 128'(c2));
    end
    @(negedge clk);
    ifs2.Flush_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
